// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Inverse of the 4-bit combinational multiplier (8-bit product / 4-bit operand).
module restoring_divider #(
    parameter int DIVIDEND_WIDTH = 8,
    parameter int DIVISOR_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    localparam int DD = DIVIDEND_WIDTH;
    localparam int DW = DIVISOR_WIDTH;
    localparam int CW = $clog2(DD + 1);
    localparam logic [CW-1:0] LAST = CW'(DD - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ZERO
    } state_t;

    state_t state, state_n;

    logic [DD-1:0] dq, dq_n, quo_n;
    logic [DW:0]   pr, pr_n;
    logic [DW-1:0] dvs, dvs_n, rem_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          done_n, dbz_n;

    // pr[DW] is always 0 between iterations, so the top bit of diff is the borrow
    logic [DW+1:0] shifted;
    logic [DW+1:0] diff;
    logic          borrow;

    assign shifted = {pr, dq[DD-1]};
    assign diff    = shifted - {2'b00, dvs};
    assign borrow  = diff[DW+1];
    assign busy    = (state != IDLE);

    always_comb begin
        state_n = state;
        dq_n    = dq;
        pr_n    = pr;
        dvs_n   = dvs;
        cnt_n   = cnt;
        quo_n   = quotient;
        rem_n   = remainder;
        dbz_n   = div_by_zero;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    dq_n    = dividend;
                    dvs_n   = divisor;
                    pr_n    = '0;
                    cnt_n   = '0;
                    state_n = (divisor == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                pr_n  = borrow ? shifted[DW:0] : diff[DW:0];
                dq_n  = {dq[DD-2:0], ~borrow};
                cnt_n = cnt + 1'b1;
                if (cnt == LAST) begin
                    quo_n   = dq_n;
                    rem_n   = pr_n[DW-1:0];
                    dbz_n   = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            ZERO: begin
                quo_n   = '1;
                rem_n   = '0;
                dbz_n   = 1'b1;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dq          <= '0;
            pr          <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            dq          <= dq_n;
            pr          <= pr_n;
            dvs         <= dvs_n;
            cnt         <= cnt_n;
            quotient    <= quo_n;
            remainder   <= rem_n;
            div_by_zero <= dbz_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: reference results from plain / and %.
// Monitor checks results, latency, output hold and reset values at negedge.
module tb_restoring_divider;

    localparam int DD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient;
    logic [3:0] remainder;

    restoring_divider #(.DIVIDEND_WIDTH(8), .DIVISOR_WIDTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int outs();
        return int'({busy, done, quotient, remainder, div_by_zero});
    endfunction

    // Monitor
    initial begin
        exp_t e;
        logic [7:0] hq;
        logic [3:0] hr;
        logic hz;
        hq = '0;
        hr = '0;
        hz = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs", outs(), 0);
                hq = '0;
                hr = '0;
                hz = 1'b0;
            end else if (done) begin
                chk("done_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("quotient", int'(quotient), int'(e.q));
                    chk("remainder", int'(remainder), int'(e.r));
                    chk("div_by_zero", int'(div_by_zero), int'(e.z));
                    chk("latency", cyc, e.cyc);
                    chk("busy_at_done", int'(busy), 0);
                    if (!e.z) begin
                        chk("invariant",
                            int'(quotient) * int'(e.b) + int'(remainder),
                            int'(e.a));
                        chk("rem_lt_div", int'(remainder < e.b), 1);
                    end
                    hq = e.q;
                    hr = e.r;
                    hz = e.z;
                end
            end else begin
                chk("hold_q", int'(quotient), int'(hq));
                chk("hold_r", int'(remainder), int'(hr));
                chk("hold_z", int'(div_by_zero), int'(hz));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is just after a rising edge; acceptance happens at the next edge.
    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 4'd0) begin
            e.q   = 8'hFF;
            e.r   = 4'd0;
            e.z   = 1'b1;
            e.cyc = cyc + 2;
        end else begin
            e.q   = 8'(a / b);
            e.r   = 4'(a % b);
            e.z   = 1'b0;
            e.cyc = cyc + 1 + DD;
        end
        sb.push_back(e);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_drain"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_outputs", outs(), 0);
        end

        issue(8'd143, 4'd11);
        chk("busy_run", int'(busy), 1);
        drain("b143_11");
        issue(8'd200, 4'd7);
        drain("b200_7");
        issue(8'd255, 4'd1);
        drain("b255_1");
        issue(8'd5, 4'd15);
        drain("b5_15");

        issue(8'd100, 4'd0);
        drain("z100_0");
        issue(8'd100, 4'd10);
        drain("z100_10");

        issue(8'd200, 4'd7);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 4'd3;
        repeat (3) tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("proto_done_seen", int'(done), 1);
        issue(8'd9, 4'd3);
        drain("proto");

        issue(8'd143, 4'd11);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", outs(), 0);
        sb.delete();
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        repeat (12) tick();
        chk("post_reset_idle", outs(), 0);
        issue(8'd143, 4'd11);
        drain("after_reset");

        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                issue(8'(a * b), 4'(b));
                drain("mul_xcheck");
            end
        end

        for (int i = 0; i < 200; i++) begin
            issue(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
            drain("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned divider. It is the inverse operation of the team's 4-bit combinational multiplier.
- Takes an 8-bit dividend (the multiplier's product width) and a 4-bit divisor. Produces the quotient and remainder by restoring division, one quotient bit per clock.
- Used wherever a multiplier result must be undone or scaled back. Also lets the multiplier bench cross-check A*B/B == A.

Parameters:
- DIVIDEND_WIDTH, 8: width of the dividend and the quotient.
- DIVISOR_WIDTH, 4: width of the divisor and the remainder.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  DIVIDEND_WIDTH  numerator; latched on the accepting edge.
- divisor  input  DIVISOR_WIDTH  denominator; latched on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; result is valid from this cycle on.
- quotient  output  DIVIDEND_WIDTH  registered result.
- remainder  output  DIVISOR_WIDTH  registered result.
- div_by_zero  output  1  registered flag for the last result.

Behaviour:
- Reset (rst_n low, asynchronous, at any time including mid-division):
  - state goes to IDLE.
  - busy, done, quotient, remainder and div_by_zero all go to 0.
  - internal dividend shift register, partial remainder and iteration counter are cleared.
- States:
  - IDLE: if start=1 at edge N, latch dividend and divisor, clear the partial remainder and counter.
    - divisor == 0: go to ZERO.
    - otherwise: go to RUN.
    - busy=1 from edge N.
  - RUN: one iteration per edge, DIVIDEND_WIDTH iterations in total.
    - Shift the partial remainder left and bring in the dividend MSB.
    - Compute trial = partial remainder − divisor, DIVISOR_WIDTH+1 bits wide, unsigned.
    - If there is no borrow: keep trial and shift quotient bit 1. Otherwise restore and shift 0.
    - At edge N+DIVIDEND_WIDTH (edge N+8 at defaults), the final iteration:
      - writes quotient and remainder;
      - sets div_by_zero=0, done=1, busy=0;
      - returns to IDLE.
  - ZERO: at edge N+1, set quotient to all ones (0xFF), remainder=0, div_by_zero=1, done=1, busy=0, and return to IDLE.
- done:
  - high for exactly one cycle per accepted request, then cleared at the next edge.
  - Never asserted without an accepted start.
- Back-to-back: start high during the done cycle (state is already IDLE) is accepted. There are no dead cycles between operations.
- start while busy=1 is ignored. It is neither queued nor able to corrupt the operation in progress.
- Input changes on dividend/divisor after the accepting edge have no effect.
- Output hold:
  - quotient, remainder and div_by_zero hold their last values until the next done.
  - They do not change during RUN. Intermediate quotient bits live in internal registers only.
- Arithmetic:
  - Fully unsigned.
  - Invariant: dividend == quotient*divisor + remainder, and remainder < divisor, whenever div_by_zero=0.
  - The partial remainder needs DIVISOR_WIDTH+1 bits so the shift cannot overflow.
- Latency:
  - DIVIDEND_WIDTH cycles from the accepting edge to done for nonzero divisors.
  - 1 cycle for a zero divisor.

Test Plan:
- Reset then idle:
  - hold rst_n low 3 cycles, release, start=0 for 5 cycles.
  - Required: busy=done=quotient=remainder=div_by_zero=0 throughout.
- Basic values, one request each:
  - dividend=143, divisor=11 → quotient=13, remainder=0, done exactly 8 edges after acceptance.
  - 200/7 → 28 r4.
  - 255/1 → 255 r0.
  - 5/15 → 0 r5.
- Divide by zero:
  - dividend=100, divisor=0 → done 1 edge after acceptance, quotient=255, remainder=0, div_by_zero=1.
  - Then 100/10 → div_by_zero back to 0, result 10 r0.
- Protocol:
  - Assert start at 3 edges mid-RUN of 200/7, with operands changed to 9/3.
  - Required: the result is still 28 r4, done pulses once, no second operation starts.
  - Then assert start in the done cycle with 9/3: accepted, result 3 r0 eight edges later.
- Reset mid-operation:
  - Start 143/11, pull rst_n low asynchronously between edges 4 and 5.
  - Required: busy and all outputs are 0 immediately, with no done pulse after release.
  - A new request 143/11 then completes correctly.
- Exhaustive cross-check against the multiplier:
  - For every A,B in 0..15 with B≠0, divide the product A*B by B.
  - Required: quotient=A, remainder=0.
  - Also run 200 random dividend/divisor pairs, checking the invariant each time.
